// File: rtl/mmult_seq_pkg.sv
// rtl/mmult_seq_pkg.sv - shared types and constants for the matrix-multiply phase sequencer
package mmult_seq_pkg;

  localparam int N_PHASES      = 5;
  localparam int DEFAULT_CNT_W = 32;

  typedef enum logic [2:0] {
    PH_INIT  = 3'd0,
    PH_READA = 3'd1,
    PH_READB = 3'd2,
    PH_SYS   = 3'd3,
    PH_WRC   = 3'd4
  } phase_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_READ = 3'd2,
    ST_SYS  = 3'd3,
    ST_WRC  = 3'd4,
    ST_FIN  = 3'd5
  } state_e;

endpackage

// File: rtl/mmult_child_launcher.sv
// rtl/mmult_child_launcher.sv - ap_ctrl_hs start/ready/done tracker for one sub-pipeline
// Holds child_start until acknowledged, measures the outstanding time and flags protocol misuse.
module mmult_child_launcher #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_i,
  input  logic             child_ready_i,
  input  logic             child_done_i,
  output logic             child_start_o,
  output logic             outstanding_o,
  output logic             completed_o,
  output logic [CNT_W-1:0] cycles_o,
  output logic             err_o
);

  logic             start_q, start_d;
  logic             out_q, out_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             handshake;

  // A done doubles as the start acknowledge.
  assign handshake   = child_ready_i | child_done_i;
  assign completed_o = out_q & child_done_i;

  always_comb begin
    start_d = start_q;
    out_d   = out_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (issue_i) begin
      start_d = 1'b1;
      out_d   = 1'b1;
      ack_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      if (start_q && handshake) begin
        start_d = 1'b0;
        ack_d   = 1'b1;
      end
      if (out_q && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (completed_o) begin
        out_d = 1'b0;
      end
    end
    if (!out_q && handshake) begin
      err_d = 1'b1;
    end
    if (completed_o && !ack_q && !child_ready_i) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      start_q <= 1'b0;
      out_q   <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      out_q   <= out_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign child_start_o = start_q;
  assign outstanding_o = out_q;
  assign cycles_o      = cnt_q;
  assign err_o         = err_q;

endmodule

// File: rtl/mmult_phase_sequencer.sv
// rtl/mmult_phase_sequencer.sv - top-level ap_ctrl_hs sequencer for init/readA/readB/systolic/writeC
// Issues each phase the same edge the previous one completes, so runs have no inter-phase bubble.
module mmult_phase_sequencer
  import mmult_seq_pkg::*;
#(
  parameter int CNT_W    = DEFAULT_CNT_W,
  parameter bit PAR_READ = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        ap_start_i,
  output logic                        ap_done_o,
  output logic                        ap_ready_o,
  output logic                        ap_idle_o,
  output logic [N_PHASES-1:0]         child_start_o,
  input  logic [N_PHASES-1:0]         child_ready_i,
  input  logic [N_PHASES-1:0]         child_done_i,
  output logic [N_PHASES*CNT_W-1:0]   phase_cycles_o,
  output logic                        protocol_err_o
);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_INIT = ST_INIT;
  localparam logic [2:0] S_READ = ST_READ;
  localparam logic [2:0] S_SYS  = ST_SYS;
  localparam logic [2:0] S_WRC  = ST_WRC;
  localparam logic [2:0] S_FIN  = ST_FIN;

  logic [2:0]          state_q, state_d;
  logic [N_PHASES-1:0] issue;
  logic [N_PHASES-1:0] comp;
  logic [N_PHASES-1:0] outstanding;
  logic [N_PHASES-1:0] errs;
  logic [N_PHASES-1:0] pending;

  // Phases still running after this cycle's completions are retired.
  assign pending = outstanding & ~comp;

  always_comb begin
    state_d = state_q;
    issue   = '0;
    case (state_q)
      S_IDLE: begin
        if (ap_start_i) begin
          state_d        = S_INIT;
          issue[PH_INIT] = 1'b1;
        end
      end
      S_INIT: begin
        if (comp[PH_INIT]) begin
          state_d         = S_READ;
          issue[PH_READA] = 1'b1;
          issue[PH_READB] = PAR_READ;
        end
      end
      S_READ: begin
        if (!PAR_READ && comp[PH_READA]) begin
          issue[PH_READB] = 1'b1;
        end
        if (PAR_READ ? ((comp[PH_READA] | comp[PH_READB]) && (pending == '0))
                     : comp[PH_READB]) begin
          state_d       = S_SYS;
          issue[PH_SYS] = 1'b1;
        end
      end
      S_SYS: begin
        if (comp[PH_SYS]) begin
          state_d       = S_WRC;
          issue[PH_WRC] = 1'b1;
        end
      end
      S_WRC: begin
        if (comp[PH_WRC]) begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  for (genvar g = 0; g < N_PHASES; g++) begin : g_phase
    mmult_child_launcher #(
      .CNT_W (CNT_W)
    ) u_launcher (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .issue_i       (issue[g]),
      .child_ready_i (child_ready_i[g]),
      .child_done_i  (child_done_i[g]),
      .child_start_o (child_start_o[g]),
      .outstanding_o (outstanding[g]),
      .completed_o   (comp[g]),
      .cycles_o      (phase_cycles_o[g*CNT_W +: CNT_W]),
      .err_o         (errs[g])
    );
  end

  assign ap_done_o      = (state_q == S_FIN);
  assign ap_ready_o     = (state_q == S_FIN);
  assign ap_idle_o      = (state_q == S_IDLE);
  assign protocol_err_o = |errs;

endmodule

// File: tb/tb_mmult_phase_sequencer.sv
// tb/tb_mmult_phase_sequencer.sv - directed bench for serial and overlapped-read sequencer builds
module tb_mmult_phase_sequencer;

  logic         clk = 1'b0;
  logic         rst[2];
  logic         start[2];
  logic [4:0]   drv[2];
  logic [4:0]   man_done[2];
  logic [4:0]   cdone[2];
  logic [4:0]   cs[2];
  logic         apd[2], apr[2], api[2], err[2];
  logic [159:0] pc[2];
  int           lat[2][5];
  int           rt[2][5];
  bit           busy[2][5];
  int           done_cnt[2];
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  assign cdone[0] = drv[0] | man_done[0];
  assign cdone[1] = drv[1] | man_done[1];

  mmult_phase_sequencer #(.CNT_W(32), .PAR_READ(1'b0)) u_ser (
    .clk_i          (clk),
    .rst_i          (rst[0]),
    .ap_start_i     (start[0]),
    .ap_done_o      (apd[0]),
    .ap_ready_o     (apr[0]),
    .ap_idle_o      (api[0]),
    .child_start_o  (cs[0]),
    .child_ready_i  (drv[0]),
    .child_done_i   (cdone[0]),
    .phase_cycles_o (pc[0]),
    .protocol_err_o (err[0])
  );

  mmult_phase_sequencer #(.CNT_W(32), .PAR_READ(1'b1)) u_par (
    .clk_i          (clk),
    .rst_i          (rst[1]),
    .ap_start_i     (start[1]),
    .ap_done_o      (apd[1]),
    .ap_ready_o     (apr[1]),
    .ap_idle_o      (api[1]),
    .child_start_o  (cs[1]),
    .child_ready_i  (drv[1]),
    .child_done_i   (cdone[1]),
    .phase_cycles_o (pc[1]),
    .protocol_err_o (err[1])
  );

  // Child model: ready+done together so that the phase is outstanding for lat cycles.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 5; i++) begin
        if (rst[d]) begin
          drv[d][i]  = 1'b0;
          busy[d][i] = 1'b0;
          rt[d][i]   = 0;
        end else if (drv[d][i]) begin
          drv[d][i] = 1'b0;
        end else if (busy[d][i]) begin
          rt[d][i] = rt[d][i] + 1;
          if (rt[d][i] == lat[d][i]) begin
            drv[d][i]  = 1'b1;
            busy[d][i] = 1'b0;
          end
        end else if (cs[d][i]) begin
          rt[d][i] = 1;
          if (lat[d][i] == 1) drv[d][i] = 1'b1;
          else busy[d][i] = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) done_cnt[d] = 0;
      else if (apd[d]) done_cnt[d] = done_cnt[d] + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts cycles from the ap_start cycle through the ap_done cycle inclusive.
  task automatic run(input int d, input int exp_total, input bit spur, input string tag);
    int n;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    start[d] = 1'b1;
    n = 1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      n++;
      if (n == 2) start[d] = 1'b0;
      if (spur && n == 3) man_done[d][4] = 1'b1;
      if (spur && n == 4) man_done[d][4] = 1'b0;
      if (apd[d]) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    chk({tag, "_total"}, 64'(n), 64'(exp_total));
    chk({tag, "_ready"}, 64'(apr[d]), 64'd1);
    @(negedge clk);
    chk({tag, "_idle"}, 64'(api[d]), 64'd1);
  endtask

  initial begin
    int base;
    int c;
    rst[0] = 1'b1; rst[1] = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    man_done[0] = '0; man_done[1] = '0;
    lat[0] = '{4, 4, 4, 4, 4};
    lat[1] = '{4, 4, 4, 4, 4};
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_idle", 64'(api[d]), 64'd1);
      chk("rst_done", 64'(apd[d]), 64'd0);
      chk("rst_ready", 64'(apr[d]), 64'd0);
      chk("rst_cs", 64'(cs[d]), 64'd0);
      chk("rst_pc", 64'(pc[d] == '0), 64'd1);
      chk("rst_err", 64'(err[d]), 64'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Serial: every phase 4 cycles, 20 + 2 overhead.
    base = done_cnt[0];
    run(0, 22, 1'b0, "ser");
    for (int i = 0; i < 5; i++) chk("ser_pc", 64'(pc[0][i*32 +: 32]), 64'd4);
    chk("ser_err", 64'(err[0]), 64'd0);
    chk("ser_pulses", 64'(done_cnt[0] - base), 64'd1);

    // Overlapped reads, readB finishes last: 4 + 9 + 4 + 4 + 2.
    lat[1] = '{4, 5, 9, 4, 4};
    run(1, 23, 1'b0, "par");
    chk("par_pc1", 64'(pc[1][32 +: 32]), 64'd5);
    chk("par_pc2", 64'(pc[1][64 +: 32]), 64'd9);
    chk("par_pc3", 64'(pc[1][96 +: 32]), 64'd4);
    chk("par_err", 64'(err[1]), 64'd0);

    // Overlapped reads completing together.
    lat[1] = '{4, 6, 6, 4, 4};
    run(1, 20, 1'b0, "same");
    chk("same_pc1", 64'(pc[1][32 +: 32]), 64'd6);
    chk("same_pc2", 64'(pc[1][64 +: 32]), 64'd6);
    chk("same_err", 64'(err[1]), 64'd0);

    // Spurious writeC done while INIT runs.
    run(0, 22, 1'b1, "spur");
    chk("spur_err", 64'(err[0]), 64'd1);
    chk("spur_pc4", 64'(pc[0][128 +: 32]), 64'd4);

    // ap_start held across three back-to-back runs.
    lat[0] = '{1, 1, 1, 1, 1};
    base = done_cnt[0];
    @(negedge clk);
    start[0] = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (c = 0; c < 50; c++) begin
        @(negedge clk);
        if (apd[0]) break;
      end
      chk("held_seen", 64'(apd[0]), 64'd1);
      if (r == 2) begin
        start[0] = 1'b0;
      end else begin
        @(negedge clk);
        chk("held_gap", 64'(cs[0][0]), 64'd0);
        @(negedge clk);
        chk("held_rise", 64'(cs[0][0]), 64'd1);
      end
    end
    repeat (5) @(negedge clk);
    chk("held_pulses", 64'(done_cnt[0] - base), 64'd3);
    chk("held_err_sticky", 64'(err[0]), 64'd1);

    // Reset while systolic is outstanding, then a fresh run.
    lat[0] = '{4, 4, 4, 4, 4};
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (c = 0; c < 100; c++) begin
      @(negedge clk);
      if (cs[0][3]) break;
    end
    chk("mid_sys", 64'(cs[0][3]), 64'd1);
    base = done_cnt[0];
    #2 rst[0] = 1'b1;
    #1;
    chk("mid_cs", 64'(cs[0]), 64'd0);
    chk("mid_idle", 64'(api[0]), 64'd1);
    chk("mid_err", 64'(err[0]), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_no_pulse", 64'(done_cnt[0]), 64'd0);
    lat[0] = '{2, 2, 2, 2, 2};
    run(0, 12, 1'b0, "rerun");
    for (int i = 0; i < 5; i++) chk("rerun_pc", 64'(pc[0][i*32 +: 32]), 64'd2);
    chk("rerun_err", 64'(err[0]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmult_phase_sequencer.md
# mmult_phase_sequencer

Top-level control FSM for the systolic matrix-multiply accelerator. It sequences the five sub-pipelines (init, readA, readB, systolic, writeC) using ap_ctrl_hs start/ready/done handshakes, and presents a single ap_ctrl_hs interface upward. It also records per-phase cycle counts of the last run for profiling. It can optionally overlap readA and readB.

## Interface
- CNT_W, 32, width of each per-phase cycle counter
- PAR_READ, 0, 1 = launch readA and readB together; 0 = strictly serial
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- ap_start  in  1  run request (level, ap_ctrl_hs)
- ap_done  out  1  one-cycle pulse at run completion
- ap_ready  out  1  one-cycle pulse, coincident with ap_done
- ap_idle  out  1  high while in IDLE
- child_start  out  5  per-phase ap_start, index 0 init, 1 readA, 2 readB, 3 systolic, 4 writeC
- child_ready  in  5  per-phase ap_ready
- child_done  in  5  per-phase ap_done (pulse)
- phase_cycles  out  5×CNT_W  per-phase cycle count of the most recent run
- protocol_err  out  1  sticky error flag

## Operation
- States: IDLE, INIT, READ, SYS, WRC, FIN.
- IDLE -> INIT when ap_start = 1.
- INIT -> READ on done[0].
- READ -> SYS once every phase launched in READ has completed.
- SYS -> WRC on done[3].
- WRC -> FIN on done[4].
- FIN -> IDLE unconditionally.
- READ, PAR_READ = 0: issue phase 1. On done[1], issue phase 2. Leave on done[2].
- READ, PAR_READ = 1: issue phases 1 and 2 together. Latch each done in a flag. Leave when both flags are set; the two dones may arrive in the same cycle or in different cycles.
- Phase issue:
  - child_start[i] rises and holds until child_ready[i] is sampled high, then drops.
  - child_done[i] also counts as ready.
  - A phase completes on child_done[i]. ready and done may coincide.
- Cycle counter:
  - Cleared on issue.
  - Increments every cycle the phase is outstanding, including the done cycle, so the minimum value is 1.
  - Saturates at 2^CNT_W−1.
  - Holds its value until that phase is next issued.
- protocol_err is set and held until reset in either case:
  - child_done[i] or child_ready[i] arrives while phase i is not outstanding. The event is otherwise ignored.
  - child_done[i] arrives for an outstanding phase whose start was never acknowledged. The event is still treated as completion.
- ap_start is sampled only in IDLE. Dropping it mid-run has no effect.

## Timing
- Reset values: ap_idle = 1; ap_done = 0; ap_ready = 0; child_start = 0; phase_cycles = 0; protocol_err = 0; state = IDLE.
- Reset asserted mid-run: all child_start drop immediately (asynchronously). No completion pulse is generated.
- ap_start high in IDLE at edge k: child_start[0] is high from k+1, and ap_idle is low from k+1.
- Phase done at edge k: the next phase's child_start is high from k+1. There is no bubble.
- done[4] at edge k: ap_done = ap_ready = 1 for cycle k+1 (FIN), and ap_idle = 1 from k+2.
- ap_start held high: the next run's child_start[0] rises at k+3.
- Overhead per run is 2 cycles (IDLE sample and FIN), beyond the sum of phase latencies.
- child_start[i] is a registered output with no combinational path from inputs. The ready-driven drop takes effect one cycle after ready is sampled.

## Structure
- Package mmult_seq_pkg holds:
  - the phase index enum and N_PHASES = 5
  - the state enum
  - the default CNT_W
- Sub-module mmult_child_launcher:
  - one instance per phase
  - inputs: issue, child_ready, child_done
  - outputs: child_start, outstanding, completed pulse, saturating counter, per-phase error
- The top-level FSM generates the issue pulses and ORs the per-phase errors into protocol_err.

## Test plan
- Serial run, PAR_READ = 0; each child returns ready+done 3 cycles after start rises -> phase_cycles all 4; ap_done pulse once; total 22 cycles from ap_start sample to ap_done.
- PAR_READ = 1; readA done after 5 cycles, readB done after 9 -> systolic starts the cycle after readB's done; phase_cycles[1] = 5, [2] = 9.
- readA and readB done in the same cycle under PAR_READ = 1 -> single transition to SYS; no protocol_err.
- ap_start held high across 3 runs -> exactly 3 ap_done pulses; child_start[0] rises 2 cycles after each ap_done.
- Spurious child_done[4] during INIT -> protocol_err = 1 and stays set; sequencing unaffected.
- Reset asserted while systolic is outstanding -> child_start = 0 and ap_idle = 1 immediately; a subsequent run completes normally with counters freshly measured.
